ram_block_reader: RTL and testbench

Read-side initiator for the 64x16 single-port RAM (1-cycle registered read latency). On a start pulse it reads a contiguous, wrapping address range and streams each word out on a valid/ready interface, absorbing downstream back-pressure without losing in-flight reads. It sits between the RAM's port and any consumer, such as a UART transmitter or DSP stage, that drains a buffer a writer filled earlier.

---
 rtl/ram_block_reader.sv | 191 +++++++++++++++++++
 tb/tb_ram_block_reader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_block_reader.sv
// Read-side initiator for a 64x16 single-port RAM: streams a wrapping address range out on valid/ready.
// Optional macro RDR_ABORT_EN adds an abort input that cancels a running transfer without a done pulse.
module ram_block_reader #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] len_m1,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  output logic          m_last,
  input  logic          m_ready,
`ifdef RDR_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          done
);

  // state  | meaning
  // IDLE   | waiting for start
  // RUN    | issuing reads while credit allows
  // DRAIN  | all reads issued, emptying the FIFO until the last word is taken
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_remaining;
  logic          r_ram_en;
  logic          r_ram_last;
  logic [AW-1:0] r_ram_addr;
  logic          r_pend;
  logic          r_pend_last;
  logic [DW-1:0] r_fifo_data [4];
  logic          r_fifo_last [4];
  logic [1:0]    r_wr_ptr;
  logic [1:0]    r_rd_ptr;
  logic [2:0]    r_count;
  logic          r_m_valid;
  logic [DW-1:0] r_m_data;
  logic          r_m_last;
  logic          r_busy;
  logic          r_done;

  logic          w_pop;
  logic          w_push;
  logic [2:0]    w_count_nxt;
  logic [1:0]    w_rd_ptr_nxt;
  logic          w_credit;
  logic [DW-1:0] w_head_data;
  logic          w_head_last;

  assign ram_en   = r_ram_en;
  assign ram_we   = 1'b0;
  assign ram_addr = r_ram_addr;
  assign ram_di   = '0;
  assign m_data   = r_m_data;
  assign m_valid  = r_m_valid;
  assign m_last   = r_m_last;
  assign busy     = r_busy;
  assign done     = r_done;

  // Next-cycle FIFO view; the output register is loaded with the head as it will be after this edge.
  always_comb begin
    w_pop        = r_m_valid & m_ready;
    w_push       = r_pend;
    w_count_nxt  = r_count + {2'b00, w_push} - {2'b00, w_pop};
    w_rd_ptr_nxt = r_rd_ptr + {1'b0, w_pop};
    // Credit counts the read being issued this cycle, which lands in the FIFO one cycle later.
    w_credit     = ({1'b0, w_count_nxt} + {3'b000, r_ram_en}) < 4'd4;
    if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_data = ram_do;
      w_head_last = r_pend_last;
    end else begin
      w_head_data = r_fifo_data[w_rd_ptr_nxt];
      w_head_last = r_fifo_last[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_ram_en    <= 1'b0;
      r_ram_last  <= 1'b0;
      r_ram_addr  <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_last[i] <= 1'b0;
      end
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_pend      <= r_ram_en;
      r_pend_last <= r_ram_last;

      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= ram_do;
        r_fifo_last[r_wr_ptr] <= r_pend_last;
        r_wr_ptr              <= r_wr_ptr + 2'd1;
      end
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      r_m_valid <= (w_count_nxt != 3'd0);
      r_m_data  <= w_head_data;
      r_m_last  <= (w_count_nxt != 3'd0) & w_head_last;

      case (r_state)
        S_IDLE: begin
          r_ram_en   <= 1'b0;
          r_ram_last <= 1'b0;
          if (start) begin
            // The first read goes out in the cycle right after start.
            r_ram_en    <= 1'b1;
            r_ram_addr  <= start_addr;
            r_ram_last  <= (len_m1 == '0);
            r_addr      <= start_addr + 1'b1;
            r_remaining <= len_m1;
            r_busy      <= 1'b1;
            r_state     <= (len_m1 == '0) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (w_credit) begin
            r_ram_en    <= 1'b1;
            r_ram_addr  <= r_addr;
            r_addr      <= r_addr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            r_ram_last  <= (r_remaining == {{(AW-1){1'b0}}, 1'b1});
            if (r_remaining == {{(AW-1){1'b0}}, 1'b1}) r_state <= S_DRAIN;
          end else begin
            r_ram_en   <= 1'b0;
            r_ram_last <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_ram_en   <= 1'b0;
          r_ram_last <= 1'b0;
          if (w_pop && r_m_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_ram_en   <= 1'b0;
          r_ram_last <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase

`ifdef RDR_ABORT_EN
      // Abort overrides everything above: drop the inflight read and the FIFO, no done pulse.
      if (abort && (r_state != S_IDLE)) begin
        r_state     <= S_IDLE;
        r_ram_en    <= 1'b0;
        r_ram_last  <= 1'b0;
        r_pend      <= 1'b0;
        r_pend_last <= 1'b0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_m_valid   <= 1'b0;
        r_m_last    <= 1'b0;
        r_busy      <= 1'b0;
        r_done      <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ram_block_reader.sv
// Scoreboard bench for ram_block_reader: expected words/addresses queued at start, checked by a monitor.
// Exercises the RDR_ABORT_EN path only when that macro is defined.
module tb_ram_block_reader;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  start_addr = '0;
  logic [5:0]  len_m1 = '0;
  logic        ram_en, ram_we;
  logic [5:0]  ram_addr;
  logic [15:0] ram_di;
  logic [15:0] ram_do = '0;
  logic [15:0] m_data;
  logic        m_valid, m_last;
  logic        m_ready = 1'b1;
  logic        busy, done;
`ifdef RDR_ABORT_EN
  logic        abort = 1'b0;
`endif

  logic [15:0] mem [64];
  logic [5:0]  exp_addr [$];
  logic [15:0] exp_data [$];
  logic        exp_last [$];

  int cyc = 0;
  int t_start = 32'h7FFF_0000;
  int n_pass = 0;
  int n_total = 0;
  int issued = 0;
  int accepted = 0;
  int done_cnt = 0;
  int done_rel = 0;
  int first_en_rel = 0;
  int first_valid_rel = 0;
  logic busy_r1 = 1'b0;
  logic busy_at_done = 1'b1;
  logic prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  ram_block_reader #(.AW(6), .DW(16)) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len_m1(len_m1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
`ifdef RDR_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // RAM model with 1-cycle registered read, preloaded with addr+0x100.
  initial for (int i = 0; i < 64; i++) mem[i] = 16'h0100 + 16'(i);
  always @(posedge CLK) if (ram_en) ram_do <= mem[ram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    int rel;
    logic [5:0]  ea;
    logic [15:0] ed;
    logic        el;
    rel = cyc - t_start + 1;
    if (prev_stall) begin
      chk("stall_valid", {31'd0, m_valid}, 1);
      chk("stall_data", {16'd0, m_data}, {16'd0, prev_data});
    end
    if (ram_en) begin
      chk("ram_we", {31'd0, ram_we}, 0);
      chk("ram_di", {16'd0, ram_di}, 0);
      chk("credit_held_lt4", {31'd0, (issued - accepted) < 4}, 1);
      if (exp_addr.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_issue: got addr %0d expected none", ram_addr);
      end else begin
        ea = exp_addr.pop_front();
        chk("ram_addr", {26'd0, ram_addr}, {26'd0, ea});
      end
      issued++;
      if (first_en_rel == 0) first_en_rel = rel;
    end
    if (m_valid && first_valid_rel == 0) first_valid_rel = rel;
    if (m_valid && m_ready) begin
      if (exp_data.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_word: got %0h expected none", m_data);
      end else begin
        ed = exp_data.pop_front();
        el = exp_last.pop_front();
        chk("m_data", {16'd0, m_data}, {16'd0, ed});
        chk("m_last", {31'd0, m_last}, {31'd0, el});
      end
      accepted++;
    end
    if (done) begin
      done_cnt++;
      done_rel = rel;
      busy_at_done = busy;
    end
    if (rel == 1) busy_r1 = busy;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
  end

  task automatic start_block(input logic [5:0] sa, input logic [5:0] lm1);
    logic [5:0] a;
    issued = 0; accepted = 0; done_cnt = 0; done_rel = 0;
    first_en_rel = 0; first_valid_rel = 0; busy_r1 = 1'b0; busy_at_done = 1'b1;
    t_start = 32'h7FFF_0000;
    for (int i = 0; i <= int'(lm1); i++) begin
      a = sa + 6'(i);
      exp_addr.push_back(a);
      exp_data.push_back(16'h0100 + {10'd0, a});
      exp_last.push_back(i == int'(lm1));
    end
    @(posedge CLK); #1;
    start = 1'b1; start_addr = sa; len_m1 = lm1;
    @(posedge CLK); #1;
    start = 1'b0;
    t_start = cyc;
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0,1; 2: ready high plus a stray start while busy.
  task automatic wait_done(input int budget, input int mode);
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK); #1;
      if (done_cnt != 0) break;
      case (mode)
        1: m_ready = ((i % 4) == 0) || ((i % 4) == 3);
        2: begin
          m_ready = 1'b1;
          start = (i == 10);
          start_addr = 6'd20;
        end
        default: m_ready = 1'b1;
      endcase
    end
    m_ready = 1'b1;
    start = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic check_end(input string tag, input int n_words);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_words"}, accepted, n_words);
    chk({tag, "_queue_empty"}, exp_data.size(), 0);
    chk({tag, "_busy_idle"}, {31'd0, busy}, 0);
  endtask

  task automatic check_basic_timing();
    chk("t_busy_rel1", {31'd0, busy_r1}, 1);
    chk("t_first_en_rel", first_en_rel, 1);
    chk("t_first_valid_rel", first_valid_rel, 3);
    chk("t_done_rel", done_rel, 7);
    chk("t_busy_at_done", {31'd0, busy_at_done}, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ram_en"}, {31'd0, ram_en}, 0);
    chk({tag, "_ram_addr"}, {26'd0, ram_addr}, 0);
    chk({tag, "_m_valid"}, {31'd0, m_valid}, 0);
    chk({tag, "_m_data"}, {16'd0, m_data}, 0);
    chk({tag, "_m_last"}, {31'd0, m_last}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
  endtask

  task automatic flush_expect();
    exp_addr.delete();
    exp_data.delete();
    exp_last.delete();
  endtask

  initial begin
    #1;
    check_outputs_zero("rst");
    repeat (3) @(posedge CLK);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge CLK);

    // Basic 4-word read from address 5.
    start_block(6'd5, 6'd3);
    wait_done(40, 0);
    check_end("basic", 4);
    check_basic_timing();

    // Wrap across the top of the address space.
    start_block(6'd62, 6'd3);
    wait_done(40, 0);
    check_end("wrap", 4);

    // Back-pressure with ready pattern 1,0,0,1.
    start_block(6'd10, 6'd15);
    wait_done(200, 1);
    check_end("bp", 16);

    // Full range with a stray start while busy.
    start_block(6'd0, 6'd63);
    wait_done(300, 2);
    check_end("full", 64);

    // Reset after three words have been taken.
    start_block(6'd5, 6'd7);
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (accepted >= 3) break;
    end
    chk("rst_mid_reached", {31'd0, accepted >= 3}, 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    flush_expect();
    repeat (3) @(posedge CLK);
    chk("rst_mid_no_done", done_cnt, 0);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge CLK);
    start_block(6'd5, 6'd3);
    wait_done(40, 0);
    check_end("after_rst", 4);
    check_basic_timing();

`ifdef RDR_ABORT_EN
    start_block(6'd0, 6'd7);
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (accepted >= 2) break;
    end
    chk("abort_reached", {31'd0, accepted >= 2}, 1);
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    chk("abort_m_valid", {31'd0, m_valid}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_ram_en", {31'd0, ram_en}, 0);
    flush_expect();
    repeat (4) @(posedge CLK);
    chk("abort_no_done", done_cnt, 0);
    start_block(6'd5, 6'd3);
    wait_done(40, 0);
    check_end("after_abort", 4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
